// File: rtl/omega_inverse_router.sv
// Three-stage pipelined 8x8 inverse omega network. Every switch routes on one
// destination bit; conflicts go to the upper input, and the dropped packets are counted.
module omega_inverse_router #(
  parameter int unsigned DW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [7:0]      in_valid,
  input  logic [23:0]     in_dest,
  input  logic [8*DW-1:0] in_data,
  input  logic            cnt_clr,
  output logic [7:0]      out_valid,
  output logic [8*DW-1:0] out_data,
  output logic            drop_pulse,
  output logic [7:0]      drop_cnt
);

  localparam int unsigned NS = 3;
  localparam int unsigned NL = 8;

  logic [NL-1:0] v_q   [NS];
  logic [2:0]    dst_q [NS][NL];
  logic [DW-1:0] dat_q [NS][NL];
  logic [NL-1:0] v_d   [NS];
  logic [2:0]    dst_d [NS][NL];
  logic [DW-1:0] dat_d [NS][NL];

  logic [NL-1:0] sin_v;
  logic [2:0]    sin_dst [NL];
  logic [DW-1:0] sin_dat [NL];

  logic          take_u, take_l;
  int unsigned   u, lo, o, sh;
  logic [3:0]    drops_d;
  logic [8:0]    sum_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          drop_pulse_q;

  always_comb begin
    drops_d = '0;
    sin_v   = '0;
    take_u  = 1'b0;
    take_l  = 1'b0;
    u = 0; lo = 0; o = 0; sh = 0;
    for (int unsigned l = 0; l < NL; l++) begin
      sin_dst[l] = '0;
      sin_dat[l] = '0;
    end
    for (int unsigned s = 0; s < NS; s++) begin
      v_d[s] = '0;
      for (int unsigned l = 0; l < NL; l++) begin
        dst_d[s][l] = '0;
        dat_d[s][l] = '0;
        if (s == 0) begin
          sin_v[l]   = in_valid[l];
          sin_dst[l] = in_dest[3*l +: 3];
          sin_dat[l] = in_data[DW*l +: DW];
        end else begin
          sin_v[l]   = v_q[s-1][l];
          sin_dst[l] = dst_q[s-1][l];
          sin_dat[l] = dat_q[s-1][l];
        end
      end
      for (int unsigned j = 0; j < NL/2; j++) begin
        u  = 2*j;
        lo = 2*j + 1;
        if (sin_v[u] && sin_v[lo] && (sin_dst[u][s] == sin_dst[lo][s]))
          drops_d = drops_d + 4'd1;
        for (int unsigned k = 0; k < 2; k++) begin
          o  = 2*j + k;
          // switch output line o lands on (o0 o2 o1) after the inverse shuffle
          sh = (o % 2) * 4 + o / 2;
          take_u = sin_v[u] && (sin_dst[u][s] == 1'(k));
          take_l = sin_v[lo] && (sin_dst[lo][s] == 1'(k)) && !take_u;
          v_d[s][sh]   = take_u | take_l;
          dst_d[s][sh] = take_u ? sin_dst[u] : sin_dst[lo];
          dat_d[s][sh] = take_u ? sin_dat[u] : sin_dat[lo];
        end
      end
    end
    sum_d      = {1'b0, drop_cnt_q} + {5'b0, drops_d};
    drop_cnt_d = cnt_clr ? '0 : (sum_d[8] ? 8'hFF : sum_d[7:0]);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned s = 0; s < NS; s++) begin
        v_q[s] <= '0;
        for (int unsigned l = 0; l < NL; l++) begin
          dst_q[s][l] <= '0;
          dat_q[s][l] <= '0;
        end
      end
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      for (int unsigned s = 0; s < NS; s++) begin
        v_q[s] <= v_d[s];
        for (int unsigned l = 0; l < NL; l++) begin
          if (v_d[s][l]) begin
            dst_q[s][l] <= dst_d[s][l];
            dat_q[s][l] <= dat_d[s][l];
          end
        end
      end
      drop_pulse_q <= (drops_d != '0);
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  always_comb begin
    out_data = '0;
    for (int unsigned l = 0; l < NL; l++)
      out_data[DW*l +: DW] = dat_q[NS-1][l];
  end

  assign out_valid  = v_q[NS-1];
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: doc/omega_inverse_router.md
# omega_inverse_router

Pipelined 8x8 self-routing inverse omega network for tagged packets. It sits on the return path of the switch fabric and carries packets from the fabric outputs back to the requesters, mirroring the forward omega network. Each of its three 2x2 switch stages routes on one destination bit and is registered. Routing conflicts are resolved by fixed priority, and the losing packets are dropped and counted.

## Interface
- DW, 8, data width of one packet payload per port.
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- in_valid  input  8  per-port packet valid; bit i = port i.
- in_dest  input  24  per-port 3-bit destination; port i at [3i+2:3i].
- in_data  input  8*DW  per-port payload; port i at [DW*i+DW-1:DW*i].
- cnt_clr  input  1  synchronous clear of drop_cnt.
- out_valid  output  8  per-output packet valid.
- out_data  output  8*DW  per-output payload, same slicing as in_data.
- drop_pulse  output  1  high for one cycle after any drop occurs anywhere in the network.
- drop_cnt  output  8  saturating count of dropped packets.

## Operation
- Three stages s = 0, 1, 2. Each stage has four 2x2 switches.
- Switch j of a stage takes lines 2j (upper) and 2j+1 (lower).
- A valid packet with dest bit s = 0 exits on line 2j; a packet with dest bit s = 1 exits on line 2j+1.
- After each switch stage, an inverse perfect shuffle moves line (l2 l1 l0) to line (l0 l2 l1).
- Three stages therefore deliver the packet to output line = dest.
- Each stage registers valid, dest and data for all 8 lines. Stage 2 registers drive out_valid and out_data directly.
- Conflict rule: both inputs of a switch are valid and request the same output. The upper input wins; the lower packet is discarded at that stage.
- Both inputs valid and requesting different outputs: both pass; no conflict.
- Invalid lines carry valid = 0. Their data registers hold their previous contents, and checkers must ignore data where valid = 0.
- drop_cnt adds the total number of drops occurring in all stages in a cycle (0..12) and saturates at 255.
- drop_pulse is registered: it is 1 in the cycle after an edge at which at least one drop occurred.
- cnt_clr = 1 at an edge sets drop_cnt to 0, discarding that cycle's drops. drop_pulse is unaffected by cnt_clr.
- No backpressure: the network accepts a full 8-packet set every cycle.

## Timing
- Latency is 3 cycles. A packet presented in cycle t is captured into stage 0 at the end of t and appears on out_valid/out_data in cycle t+3.
- Throughput is one packet per port per cycle, fully pipelined; consecutive cycles never interact.
- A drop at stage s of a packet presented in cycle t updates drop_cnt at the edge ending cycle t+s.
- drop_pulse for that drop is visible in cycle t+s+1.
- Reset values: out_valid = 0, out_data = 0, drop_pulse = 0, drop_cnt = 0, and all internal stage valid and data registers = 0.
- Reset asserted mid-operation discards all in-flight packets immediately (asynchronous). The first packets presented after RST deasserts appear 3 cycles later.
- Saturation: drop_cnt = 255 stays 255 until cnt_clr or RST.

## Test plan
- Identity routing: all in_valid = 0xFF, dest i = i, data i = 0x10+i -> in cycle t+3, out_valid = 0xFF and out_data slice i = 0x10+i; drop_cnt stays 0 and drop_pulse stays 0.
- XOR permutation: dest i = i^7, 8 consecutive cycles with changing data -> every packet arrives at output i^7 after 3 cycles, back-to-back; no drops.
- Single packet: port 5, dest 2, data 0xA5 -> out_valid = 0x04 and out_data slice 2 = 0xA5 in cycle t+3 only.
- Stage-0 conflict: ports 0 and 1 both dest 0, data 0x11 and 0x22 -> out 0 = 0x11 at t+3; drop_cnt = 1 after the edge ending t; drop_pulse high only in cycle t+1.
- Saturation and clear: 300 consecutive cycles of the stage-0 conflict -> drop_cnt = 255. Then cnt_clr = 1 in a conflict cycle -> drop_cnt = 0. The next conflict cycle -> drop_cnt = 1.
- Reset mid-flight: identity traffic, assert RST in cycle t+1 for one cycle -> out_valid = 0 and drop_cnt = 0 immediately. Packets presented after deassertion emerge 3 cycles later, and no pre-reset packet ever appears.
